sipo_deser: RTL and testbench



---
 rtl/sipo_deser_pkg.sv | 18 +
 rtl/sipo_deser_obuf.sv | 47 ++++
 rtl/sipo_deser.sv | 134 +++++++++++++
 tb/tb_sipo_deser.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the sipo_deser serial-in/parallel-out deserializer.
package sipo_deser_pkg;

    // Frame phase: data bits, then (parity build only) the trailing parity bit
    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    // XOR over data bits plus parity bit for a correctly formed even-parity frame
    localparam logic EVEN_PARITY = 1'b0;

    // Bit counter must be able to hold WIDTH itself (held there during S_PAR)
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_deser_obuf.sv
// One-entry valid/ready holding register for sipo_deser.
// A completed word loads when the entry is empty or draining this cycle;
// otherwise it is dropped and the sticky overflow flag is set.
module sipo_deser_obuf #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    output logic [DW-1:0] data,
    output logic          vld,
    input  logic          rdy,
    output logic          ovf
);

    logic drain;
    logic accept;
    logic drop;

    // Classify this cycle's buffer activity
    always_comb begin
        drain  = vld && rdy;
        accept = load && (!vld || drain);
        drop   = load && vld && !rdy;
    end

    // Holding register, valid flag and sticky overflow; data holds after a drain
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            vld  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (accept) begin
                data <= load_data;
                vld  <= 1'b1;
            end else if (drain) begin
                vld  <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: collects WIDTH bits from a registered
// bit stream into a word and hands it to a one-entry valid/ready buffer.
// Optional feature macro: SIPO_DESER_PARITY_EN (adds trailing even-parity bit
// and the perr output).
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             out_rdy,
    output logic             ovf,
    output logic             busy
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic             perr
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned PW = 1;
`else
    localparam int unsigned PW = 0;
`endif
    localparam int unsigned OW = WIDTH + PW;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] shifted;
    logic             cpl;
    logic [OW-1:0]    cpl_word;
    logic [OW-1:0]    buf_data;

    // Shift register with the incoming bit inserted at the ordering-dependent end
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sreg_q[WIDTH-2:0], din};
        end else begin
            shifted = {din, sreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: bit collection, frame phase and word completion
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        cpl      = 1'b0;
        cpl_word = '0;
        case (state_q)
            S_DATA: begin
                if (din_vld) begin
                    sreg_d = shifted;
                    if (cnt_q == CNT_LAST) begin
`ifdef SIPO_DESER_PARITY_EN
                        cnt_d   = cnt_q + CW'(1);
                        state_d = S_PAR;
`else
                        cnt_d    = '0;
                        cpl      = 1'b1;
                        cpl_word = shifted;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef SIPO_DESER_PARITY_EN
            S_PAR: begin
                // perr rides in the buffer MSB so it loads/drops with its word
                if (din_vld) begin
                    cnt_d    = '0;
                    state_d  = S_DATA;
                    cpl      = 1'b1;
                    cpl_word = {((^sreg_q) ^ din) != EVEN_PARITY, sreg_q};
                end
            end
`endif
            default: begin
                state_d = S_DATA;
            end
        endcase
    end

    // State, counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

    // Partial word in progress
    always_comb begin
        busy = (cnt_q != '0);
    end

    sipo_deser_obuf #(
        .DW(OW)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .load     (cpl),
        .load_data(cpl_word),
        .data     (buf_data),
        .vld      (dout_vld),
        .rdy      (out_rdy),
        .ovf      (ovf)
    );

    // Split buffered entry into data word and (optional) parity error flag
    always_comb begin
`ifdef SIPO_DESER_PARITY_EN
        {perr, dout} = buf_data;
`else
        dout = buf_data;
`endif
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (WIDTH=8), LSB-first and
// MSB-first instances driven from the same stimulus.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_vld;
    logic       out_rdy;
    logic [7:0] dout0, dout1;
    logic       vld0, vld1;
    logic       ovf0, ovf1;
    logic       busy0, busy1;
`ifdef SIPO_DESER_PARITY_EN
    logic       perr0, perr1;
    logic       par_inject = 1'b0;
`endif

    int unsigned tests_run = 0;
    int unsigned fail_cnt  = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .dout(dout0), .dout_vld(vld0), .out_rdy(out_rdy),
        .ovf(ovf0), .busy(busy0)
`ifdef SIPO_DESER_PARITY_EN
        , .perr(perr0)
`endif
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .dout(dout1), .dout_vld(vld1), .out_rdy(out_rdy),
        .ovf(ovf1), .busy(busy1)
`ifdef SIPO_DESER_PARITY_EN
        , .perr(perr1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din     = b;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        din     = 1'b0;
    endtask

    // Sends v[0] first; out_rdy is switched to rdy_last on the completing bit
    task automatic send_word(input logic [7:0] v, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
`ifndef SIPO_DESER_PARITY_EN
            if (i == 7) out_rdy = rdy_last;
`endif
            send_bit(v[i]);
        end
`ifdef SIPO_DESER_PARITY_EN
        out_rdy = rdy_last;
        send_bit((^v) ^ par_inject);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        rst     = 1'b1;
        din     = 1'b0;
        din_vld = 1'b0;
        out_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_dout", dout0, 8'h00);
        check("rst_vld",  vld0,  1'b0);
        check("rst_ovf",  ovf0,  1'b0);
        check("rst_busy", busy0, 1'b0);

        // Basic word, both bit orders
        send_word(8'h4D, 1'b1);
        check("basic_dout", dout0, 8'h4D);
        check("basic_vld",  vld0,  1'b1);
        check("basic_ovf",  ovf0,  1'b0);
        check("basic_busy", busy0, 1'b0);
        check("msb_dout",   dout1, 8'hB2);
        check("msb_vld",    vld1,  1'b1);
        tick();
        check("drain_vld",  vld0,  1'b0);
        check("drain_hold", dout0, 8'h4D);

        // Strobe gap of 3 cycles between bits 4 and 5
        v = 8'h4D;
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        for (int g = 0; g < 3; g++) begin
            tick();
            check("gap_busy", busy0, 1'b1);
            check("gap_vld",  vld0,  1'b0);
        end
        for (int i = 4; i < 8; i++) send_bit(v[i]);
        check("gap_dout", dout0, 8'h4D);
        check("gap_vld2", vld0,  1'b1);
        tick();

        // Backpressure then overflow
        out_rdy = 1'b0;
        send_word(8'h4D, 1'b0);
        check("bp_vld",  vld0,  1'b1);
        check("bp_dout", dout0, 8'h4D);
        check("bp_ovf0", ovf0,  1'b0);
        send_word(8'hFF, 1'b0);
        check("ovf_dout", dout0, 8'h4D);
        check("ovf_vld",  vld0,  1'b1);
        check("ovf_set",  ovf0,  1'b1);
        out_rdy = 1'b1;
        tick();
        check("ovf_drain_vld",  vld0,  1'b0);
        check("ovf_sticky",     ovf0,  1'b1);
        check("ovf_drain_dout", dout0, 8'h4D);

        // Drain and load on the same edge
        do_reset();
        check("rst2_ovf", ovf0, 1'b0);
        out_rdy = 1'b0;
        send_word(8'h4D, 1'b0);
        check("sim_first", dout0, 8'h4D);
        send_word(8'h12, 1'b1);
        check("sim_dout", dout0, 8'h12);
        check("sim_vld",  vld0,  1'b1);
        check("sim_ovf",  ovf0,  1'b0);
        tick();
        check("sim_drain", vld0, 1'b0);

        // Reset in the middle of a word; rst wins over an active strobe
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("mid_busy", busy0, 1'b1);
        rst     = 1'b1;
        din     = 1'b1;
        din_vld = 1'b1;
        tick();
        rst     = 1'b0;
        din_vld = 1'b0;
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_vld",  vld0,  1'b0);
        check("mid_rst_dout", dout0, 8'h00);
        send_word(8'h0F, 1'b1);
        check("mid_dout",     dout0, 8'h0F);
        check("mid_vld",      vld0,  1'b1);
        check("mid_busy_end", busy0, 1'b0);
        check("mid_msb_dout", dout1, 8'hF0);
        tick();

`ifdef SIPO_DESER_PARITY_EN
        // Parity bit correct, then corrupted
        par_inject = 1'b0;
        send_word(8'h4D, 1'b1);
        check("par_ok_dout", dout0, 8'h4D);
        check("par_ok_perr", perr0, 1'b0);
        tick();
        par_inject = 1'b1;
        send_word(8'h4D, 1'b1);
        check("par_bad_dout", dout0, 8'h4D);
        check("par_bad_perr", perr0, 1'b1);
        check("par_bad_vld",  vld0,  1'b1);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
